// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-add multiplier: default sizes
// and the control state encoding.
package mult_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 6;

    // 2'b11 is not a legal encoding; the controller returns to IDLE from it.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

endpackage

// File: rtl/mult32_control.sv
// Control FSM for the shift-add multiplier: iteration counter, busy/done
// decode and the operand load enable.
module mult32_control
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   start,
    output state_t state,
    output logic   busy,
    output logic   done,
    output logic   load
);

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_d;
    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_d;
            if (load) begin
                count <= '0;
            end else if (state == RUN) begin
                count <= count + 1'b1;
            end
        end
    end

    // start is only looked at in IDLE, so requests while busy fall away.
    always_comb begin
        state_d = state;
        busy    = 1'b0;
        done    = 1'b0;
        load    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (count == LAST_ITER) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: rtl/mult32_seq.sv
// Sequential unsigned multiplier: 65-bit product/multiplier register updated
// once per clock by a conditional add of the multiplicand followed by a shift.
module mult32_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    state_t           state;
    logic             load;
    logic [WIDTH-1:0] mcand;
    logic [2*WIDTH:0] p;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   upper;

    mult32_control #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_control (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .state (state),
        .busy  (busy),
        .done  (done),
        .load  (load)
    );

    // p[2*WIDTH] is zero throughout RUN, so the 33-bit sum keeps the carry.
    assign sum   = p[2*WIDTH:WIDTH] + {1'b0, mcand};
    assign upper = p[0] ? sum : p[2*WIDTH:WIDTH];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            p     <= '0;
        end else if (load) begin
            mcand <= a;
            p     <= {{(WIDTH+1){1'b0}}, b};
        end else if (state == RUN) begin
            p <= {1'b0, upper, p[WIDTH-1:1]};
        end
    end

    assign product = p[2*WIDTH-1:0];

endmodule
